// File: rtl/iq_rotator_pkg.sv
// Shared mode encoding, default parameters and the elaboration-time sine coefficient generator.
// No logic of its own; imported by the rotator and its coefficient LUT.
package iq_rotator_pkg;

   typedef enum logic [1:0] {
      MODE_BYPASS = 2'd0,
      MODE_ROTATE = 2'd1,
      MODE_CONJ   = 2'd2,
      MODE_ZERO   = 2'd3
   } mode_e;

   localparam int DEF_LANES   = 5;
   localparam int DEF_DATA_W  = 16;
   localparam int DEF_PHASE_W = 8;
   localparam int DEF_COEF_W  = 16;

   // pi with 48 fractional bits, taken directly from its hex expansion
   localparam int                 TRIG_FRAC = 48;
   localparam logic signed [127:0] PI_FX    = 128'sh3_243F_6A88_85A3;

   // round((2^(coef_w-1)-1) * sin(2*pi*k / 2^phase_w)) for a first-quadrant code k.
   // Only ever evaluated on constants, so the wide fixed-point Taylor series costs no hardware.
   function automatic int sin_coef(input int k, input int phase_w, input int coef_w);
      logic signed [127:0] x, x2, term, acc, cmax;
      x    = (PI_FX * 128'(k)) >>> (phase_w - 1);
      x2   = (x * x) >>> TRIG_FRAC;
      term = x;
      acc  = x;
      for (int n = 1; n < 12; n++) begin
         term = -(((term * x2) >>> TRIG_FRAC) / 128'(2 * n * (2 * n + 1)));
         acc  = acc + term;
      end
      cmax = (128'sd1 <<< (coef_w - 1)) - 128'sd1;
      acc  = (acc * cmax + (128'sd1 <<< (TRIG_FRAC - 1))) >>> TRIG_FRAC;
      return int'(acc);
   endfunction

endpackage

// File: rtl/sincos_lut.sv
// Phase to cos/sin coefficient lookup from a quarter-wave table; one registered stage.
// Holds its output whenever en is low so it stalls in step with the surrounding pipeline.
module sincos_lut
   import iq_rotator_pkg::*;
#(
   parameter int PHASE_W = DEF_PHASE_W,
   parameter int COEF_W  = DEF_COEF_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [PHASE_W-1:0]       phase,
   output logic signed [COEF_W-1:0] cos_out,
   output logic signed [COEF_W-1:0] sin_out
);

   localparam int QTR   = 1 << (PHASE_W - 2);
   localparam int IDX_W = PHASE_W - 1;

   logic signed [COEF_W-1:0] tab [QTR+1];

   for (genvar k = 0; k <= QTR; k++) begin : g_tab
      localparam int V = sin_coef(k, PHASE_W, COEF_W);
      assign tab[k] = COEF_W'(V);
   end

   logic [IDX_W-1:0]         idx_a, idx_b;
   logic signed [COEF_W-1:0] ta, tb;
   logic signed [COEF_W-1:0] cos_d, cos_q, sin_d, sin_q;

   always_comb begin
      idx_a = {1'b0, phase[PHASE_W-3:0]};
      idx_b = IDX_W'(QTR) - idx_a;
      ta    = tab[idx_a];
      tb    = tab[idx_b];
      cos_d = cos_q;
      sin_d = sin_q;
      // Quadrant folding; table entries never reach -2^(COEF_W-1), so negation is exact
      if (en) begin
         case (phase[PHASE_W-1 -: 2])
            2'd0:    begin cos_d =  tb; sin_d =  ta; end
            2'd1:    begin cos_d = -ta; sin_d =  tb; end
            2'd2:    begin cos_d = -tb; sin_d = -ta; end
            default: begin cos_d =  ta; sin_d = -tb; end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cos_q <= '0;
         sin_q <= '0;
      end else begin
         cos_q <= cos_d;
         sin_q <= sin_d;
      end
   end

   assign cos_out = cos_q;
   assign sin_out = sin_q;

endmodule

// File: rtl/iq_rotator.sv
// Multi-lane complex rotator (bypass/rotate/conjugate/zero per beat); 3-cycle latency.
// One global stall: every stage holds and in_ready drops while out_valid waits on out_ready.
module iq_rotator
   import iq_rotator_pkg::*;
#(
   parameter int LANES   = DEF_LANES,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int PHASE_W = DEF_PHASE_W,
   parameter int COEF_W  = DEF_COEF_W
) (
   input  logic                                   clk100,
   input  logic                                   reset_n,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [1:0]                             mode,
   input  logic [LANES-1:0][PHASE_W-1:0]          phase_vals,
   input  logic [LANES-1:0][DATA_W-1:0]           data_i_in,
   input  logic [LANES-1:0][DATA_W-1:0]           data_q_in,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [LANES-1:0][DATA_W+COEF_W-1:0]    data_i_rot,
   output logic [LANES-1:0][DATA_W+COEF_W-1:0]    data_q_rot
);

   localparam int OUT_W = DATA_W + COEF_W;

   logic en;

   logic                             s1_vld_d, s1_vld_q;
   mode_e                            s1_mode_d, s1_mode_q;
   logic [LANES-1:0][DATA_W-1:0]     s1_i_d, s1_i_q, s1_q_d, s1_q_q;
   logic [LANES-1:0][COEF_W-1:0]     s1_cos, s1_sin;

   logic                             s2_vld_d, s2_vld_q;
   mode_e                            s2_mode_d, s2_mode_q;
   logic [LANES-1:0][OUT_W-1:0]      s2_ic_d, s2_ic_q, s2_qs_d, s2_qs_q;
   logic [LANES-1:0][OUT_W-1:0]      s2_is_d, s2_is_q, s2_qc_d, s2_qc_q;
   logic [LANES-1:0][DATA_W-1:0]     s2_i_d, s2_i_q, s2_q_d, s2_q_q;

   logic                             out_vld_d, out_vld_q;
   logic [LANES-1:0][OUT_W-1:0]      out_i_d, out_i_q, out_q_d, out_q_q;

   logic signed [COEF_W-1:0]         sin_eff;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      sincos_lut #(
         .PHASE_W (PHASE_W),
         .COEF_W  (COEF_W)
      ) u_lut (
         .clk     (clk100),
         .rst_n   (reset_n),
         .en      (en),
         .phase   (phase_vals[k]),
         .cos_out (s1_cos[k]),
         .sin_out (s1_sin[k])
      );
   end

   always_comb begin
      en        = out_ready || !out_vld_q;
      s1_vld_d  = s1_vld_q;
      s1_mode_d = s1_mode_q;
      s1_i_d    = s1_i_q;
      s1_q_d    = s1_q_q;
      s2_vld_d  = s2_vld_q;
      s2_mode_d = s2_mode_q;
      s2_ic_d   = s2_ic_q;
      s2_qs_d   = s2_qs_q;
      s2_is_d   = s2_is_q;
      s2_qc_d   = s2_qc_q;
      s2_i_d    = s2_i_q;
      s2_q_d    = s2_q_q;
      out_vld_d = out_vld_q;
      out_i_d   = out_i_q;
      out_q_d   = out_q_q;
      sin_eff   = '0;
      if (en) begin
         s1_vld_d  = in_valid;
         s1_mode_d = mode_e'(mode);
         s1_i_d    = data_i_in;
         s1_q_d    = data_q_in;
         s2_vld_d  = s1_vld_q;
         s2_mode_d = s1_mode_q;
         s2_i_d    = s1_i_q;
         s2_q_d    = s1_q_q;
         out_vld_d = s2_vld_q;
         for (int k = 0; k < LANES; k++) begin
            // Conjugate rotation is the same datapath with the sine negated
            sin_eff    = (s1_mode_q == MODE_CONJ) ? -s1_sin[k] : s1_sin[k];
            s2_ic_d[k] = OUT_W'($signed(s1_i_q[k])) * OUT_W'($signed(s1_cos[k]));
            s2_qs_d[k] = OUT_W'($signed(s1_q_q[k])) * OUT_W'(sin_eff);
            s2_is_d[k] = OUT_W'($signed(s1_i_q[k])) * OUT_W'(sin_eff);
            s2_qc_d[k] = OUT_W'($signed(s1_q_q[k])) * OUT_W'($signed(s1_cos[k]));
            // Sum of two products is bounded by 2^(OUT_W-1)-2^DATA_W, so modular add is exact
            case (s2_mode_q)
               MODE_BYPASS: begin
                  out_i_d[k] = OUT_W'($signed(s2_i_q[k])) << (COEF_W - 1);
                  out_q_d[k] = OUT_W'($signed(s2_q_q[k])) << (COEF_W - 1);
               end
               MODE_ZERO: begin
                  out_i_d[k] = '0;
                  out_q_d[k] = '0;
               end
               default: begin
                  out_i_d[k] = s2_ic_q[k] - s2_qs_q[k];
                  out_q_d[k] = s2_is_q[k] + s2_qc_q[k];
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk100 or negedge reset_n) begin
      if (!reset_n) begin
         s1_vld_q  <= 1'b0;
         s1_mode_q <= MODE_BYPASS;
         s1_i_q    <= '0;
         s1_q_q    <= '0;
         s2_vld_q  <= 1'b0;
         s2_mode_q <= MODE_BYPASS;
         s2_ic_q   <= '0;
         s2_qs_q   <= '0;
         s2_is_q   <= '0;
         s2_qc_q   <= '0;
         s2_i_q    <= '0;
         s2_q_q    <= '0;
         out_vld_q <= 1'b0;
         out_i_q   <= '0;
         out_q_q   <= '0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_mode_q <= s1_mode_d;
         s1_i_q    <= s1_i_d;
         s1_q_q    <= s1_q_d;
         s2_vld_q  <= s2_vld_d;
         s2_mode_q <= s2_mode_d;
         s2_ic_q   <= s2_ic_d;
         s2_qs_q   <= s2_qs_d;
         s2_is_q   <= s2_is_d;
         s2_qc_q   <= s2_qc_d;
         s2_i_q    <= s2_i_d;
         s2_q_q    <= s2_q_d;
         out_vld_q <= out_vld_d;
         out_i_q   <= out_i_d;
         out_q_q   <= out_q_d;
      end
   end

   assign in_ready   = en;
   assign out_valid  = out_vld_q;
   assign data_i_rot = out_i_q;
   assign data_q_rot = out_q_q;

endmodule
